// File: rtl/oka_pkg.sv
// oka_pkg: shared state encoding, widths and per-phase accumulate term for the sequenced OKA64 multiplier
package oka_pkg;
  localparam int HALF_W = 32;
  localparam int PROD_W = 63;
  localparam int FULL_W = 127;
  typedef enum logic [2:0] {IDLE, MUL_L, MUL_M, MUL_H, ACC_H, DONE} state_t;
  function automatic logic [FULL_W-1:0] acc_term(input state_t ph, input logic [PROD_W-1:0] p);
    logic [FULL_W-1:0] e;
    e = {{(FULL_W-PROD_W){1'b0}}, p};
    return ph == MUL_L ? e ^ (e << HALF_W) :
           ph == MUL_M ? e << HALF_W :
                         (e << HALF_W) ^ (e << 2*HALF_W);
  endfunction
endpackage

// File: rtl/oka_32bit.sv
// OKA_32bit: combinational 32x32 carry-less multiplier, one Karatsuba level over 16-bit schoolbook products
module OKA_32bit
  import oka_pkg::*;
(
  input  logic [HALF_W-1:0] a_i,
  input  logic [HALF_W-1:0] b_i,
  output logic [PROD_W-1:0] p_o
);
  function automatic logic [30:0] cl16(input logic [15:0] x, input logic [15:0] y);
    logic [30:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r ^= y[i] ? ({15'b0, x} << i) : 31'b0;
    return r;
  endfunction
  logic [30:0] z0, z1, z2;
  assign z0 = cl16(a_i[15:0], b_i[15:0]);
  assign z1 = cl16(a_i[15:0] ^ a_i[31:16], b_i[15:0] ^ b_i[31:16]);
  assign z2 = cl16(a_i[31:16], b_i[31:16]);
  assign p_o = {32'b0, z0} ^ ({32'b0, z0 ^ z1 ^ z2} << 16) ^ ({32'b0, z2} << 32);
endmodule

// File: rtl/oka64_seq.sv
// oka64_seq: 64x64 carry-less multiplier sharing one 32-bit OKA core over low/middle/high phases.
// Define OKA64_SEQ_PIPE_EN to register the core product, adding the ACC_H state and one cycle of latency.
module oka64_seq
  import oka_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [63:0]       a,
  input  logic [63:0]       b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FULL_W-1:0] y,
  output logic              busy,
  output logic [CNT_W-1:0]  op_cnt
);
  state_t state_q, state_d, acc_ph;
  logic [63:0] a_q, b_q;
  logic [FULL_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [HALF_W-1:0] mul_a, mul_b;
  logic [PROD_W-1:0] prod, acc_p;
  logic take, give, acc_en;
  assign take = state_q == IDLE && in_valid;
  assign give = state_q == DONE && out_ready;
  assign mul_a = state_q == MUL_L ? a_q[31:0] : state_q == MUL_M ? a_q[31:0] ^ a_q[63:32] : a_q[63:32];
  assign mul_b = state_q == MUL_L ? b_q[31:0] : state_q == MUL_M ? b_q[31:0] ^ b_q[63:32] : b_q[63:32];
  OKA_32bit u_mul (.a_i(mul_a), .b_i(mul_b), .p_o(prod));
`ifdef OKA64_SEQ_PIPE_EN
  localparam state_t H_NEXT = ACC_H;
  logic [PROD_W-1:0] prod_q;
  // each accumulate lands one state after its issue, so it uses the previous phase's term
  assign acc_en = state_q inside {MUL_M, MUL_H, ACC_H};
  assign acc_ph = state_q == MUL_M ? MUL_L : state_q == MUL_H ? MUL_M : MUL_H;
  assign acc_p = prod_q;
  always_ff @(posedge clk) begin
    if (!rst_n) prod_q <= '0;
    else prod_q <= prod;
  end
`else
  localparam state_t H_NEXT = DONE;
  assign acc_en = state_q inside {MUL_L, MUL_M, MUL_H};
  assign acc_ph = state_q;
  assign acc_p = prod;
`endif
  always_comb begin
    state_d = state_q == IDLE  ? (in_valid ? MUL_L : IDLE) :
              state_q == MUL_L ? MUL_M :
              state_q == MUL_M ? MUL_H :
              state_q == MUL_H ? H_NEXT :
              state_q == ACC_H ? DONE :
                                 (out_ready ? IDLE : DONE);
    acc_d = take ? '0 : acc_en ? acc_q ^ acc_term(acc_ph, acc_p) : acc_q;
    op_cnt_d = give && !(&op_cnt_q) ? op_cnt_q + CNT_W'(1) : op_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      op_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        a_q <= a;
        b_q <= b;
      end
      acc_q <= acc_d;
      op_cnt_q <= op_cnt_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign out_valid = state_q == DONE;
  assign y = acc_q;
  assign op_cnt = op_cnt_q;
endmodule
